// File: rtl/intdiv_seq_if.sv
// rtl/intdiv_seq_if.sv - operand/result handshakes and divider connection of intdiv_seq
interface intdiv_seq_if #(
    parameter int N    = 4,
    parameter int TAGW = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_x;
    logic [N-1:0]    in_y;
    logic [TAGW-1:0] in_tag;
    logic [N-1:0]    div_x;
    logic [N-1:0]    div_y;
    logic [N-1:0]    div_z;
    logic [N-1:0]    div_r;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_z;
    logic [N-1:0]    out_r;
    logic [TAGW-1:0] out_tag;
    logic            out_dz;
    logic            out_ovf;
    logic            busy;

    modport slave (
        input  in_valid, in_x, in_y, in_tag, div_z, div_r, out_ready,
        output in_ready, div_x, div_y, out_valid, out_z, out_r, out_tag,
               out_dz, out_ovf, busy
    );

    modport master (
        output in_valid, in_x, in_y, in_tag, div_z, div_r, out_ready,
        input  in_ready, div_x, div_y, out_valid, out_z, out_r, out_tag,
               out_dz, out_ovf, busy
    );
endinterface

// File: rtl/intdiv_seq.sv
// rtl/intdiv_seq.sv - credit-gated issue/collect sequencer around a fixed-latency signed divider
module intdiv_seq #(
    parameter int N     = 4,
    parameter int LAT   = 6,
    parameter int DEPTH = 4,
    parameter int TAGW  = 2
) (
    input  logic        clock,
    input  logic        reset,
    intdiv_seq_if.slave bus
);
    localparam int IW = $clog2(LAT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = ((IW > CW) ? IW : CW) + 1;

    logic            accept, push, pop;
    logic            in_dz, in_ovf;
    logic [N-1:0]    in_sz, in_sr, push_z, push_r;
    logic [SW-1:0]   credits_used;

    logic [N-1:0]    div_x_q, div_y_q;
    logic            dl_valid_q [LAT];
    logic            dl_dz_q    [LAT];
    logic            dl_ovf_q   [LAT];
    logic [TAGW-1:0] dl_tag_q   [LAT];
    logic [N-1:0]    dl_z_q     [LAT];
    logic [N-1:0]    dl_r_q     [LAT];

    logic [N-1:0]    fifo_z_q   [DEPTH];
    logic [N-1:0]    fifo_r_q   [DEPTH];
    logic [TAGW-1:0] fifo_tag_q [DEPTH];
    logic            fifo_dz_q  [DEPTH];
    logic            fifo_ovf_q [DEPTH];

    logic [IW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // Every op in the delay line already owns a FIFO slot, so the divider never needs to stall.
    assign credits_used = SW'(inflight_q) + SW'(count_q);
    assign bus.in_ready = !reset && (credits_used < SW'(DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = dl_valid_q[LAT-1];
    assign pop          = bus.out_valid && bus.out_ready;

    always_comb begin
        in_dz  = (bus.in_y == '0);
        in_ovf = (bus.in_x == {1'b1, {(N-1){1'b0}}}) && (bus.in_y == '1);
        in_sz  = in_dz ? '1 : bus.in_x;
        in_sr  = in_dz ? bus.in_x : '0;
    end

    always_comb begin
        if (dl_dz_q[LAT-1] || dl_ovf_q[LAT-1]) begin
            push_z = dl_z_q[LAT-1];
            push_r = dl_r_q[LAT-1];
        end else begin
            push_z = bus.div_z;
            push_r = bus.div_r;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, push})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_x_q    <= '0;
            div_y_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_valid_q[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                div_x_q <= bus.in_x;
                div_y_q <= bus.in_y;
            end
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            dl_valid_q[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind a valid bit or a FIFO count.
    always_ff @(posedge clock) begin
        dl_tag_q[0] <= bus.in_tag;
        dl_dz_q[0]  <= in_dz;
        dl_ovf_q[0] <= in_ovf;
        dl_z_q[0]   <= in_sz;
        dl_r_q[0]   <= in_sr;
        for (int i = 1; i < LAT; i++) begin
            dl_tag_q[i] <= dl_tag_q[i-1];
            dl_dz_q[i]  <= dl_dz_q[i-1];
            dl_ovf_q[i] <= dl_ovf_q[i-1];
            dl_z_q[i]   <= dl_z_q[i-1];
            dl_r_q[i]   <= dl_r_q[i-1];
        end
        if (push) begin
            fifo_z_q[wr_ptr_q]   <= push_z;
            fifo_r_q[wr_ptr_q]   <= push_r;
            fifo_tag_q[wr_ptr_q] <= dl_tag_q[LAT-1];
            fifo_dz_q[wr_ptr_q]  <= dl_dz_q[LAT-1];
            fifo_ovf_q[wr_ptr_q] <= dl_ovf_q[LAT-1];
        end
    end

    assign bus.div_x     = div_x_q;
    assign bus.div_y     = div_y_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_z     = fifo_z_q[rd_ptr_q];
    assign bus.out_r     = fifo_r_q[rd_ptr_q];
    assign bus.out_tag   = fifo_tag_q[rd_ptr_q];
    assign bus.out_dz    = fifo_dz_q[rd_ptr_q];
    assign bus.out_ovf   = fifo_ovf_q[rd_ptr_q];
    assign bus.busy      = (inflight_q != '0) || (count_q != '0);
endmodule

// File: tb/tb_intdiv_seq.sv
// tb/tb_intdiv_seq.sv - randomized self-checking bench for intdiv_seq against a queue-based result model
module tb_intdiv_seq;
    localparam int N     = 4;
    localparam int LAT   = 6;
    localparam int DEPTH = 4;
    localparam int TAGW  = 2;

    typedef struct {
        logic [N-1:0]    z;
        logic [N-1:0]    r;
        logic [TAGW-1:0] tag;
        logic            dz;
        logic            ovf;
        int              acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges    = 0;
    exp_t exp_q[$];

    intdiv_seq_if #(.N(N), .TAGW(TAGW)) bus ();

    intdiv_seq #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Divider stand-in: results for the operands presented LAT edges earlier; garbage on special cases.
    logic [N-1:0] px [LAT-1];
    logic [N-1:0] py [LAT-1];
    always @(posedge clock) begin
        px[0] <= bus.div_x;
        py[0] <= bus.div_y;
        for (int i = 1; i < LAT - 1; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    always_comb begin
        int xi, yi;
        xi = int'($signed(px[LAT-2]));
        yi = int'($signed(py[LAT-2]));
        bus.div_z = '0;
        bus.div_r = '1;
        if (yi != 0 && !(xi == -(1 << (N - 1)) && yi == -1)) begin
            bus.div_z = N'(xi / yi);
            bus.div_r = N'(xi % yi);
        end
    end

    function automatic exp_t ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                    input logic [TAGW-1:0] tag, input int acc);
        exp_t e;
        int xi, yi;
        xi = int'($signed(x));
        yi = int'($signed(y));
        e.tag = tag;
        e.acc = acc;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (yi == 0) begin
            e.dz = 1'b1;
            e.z  = '1;
            e.r  = x;
        end else if (xi == -(1 << (N - 1)) && yi == -1) begin
            e.ovf = 1'b1;
            e.z   = x;
            e.r   = '0;
        end else begin
            e.z = N'(xi / yi);
            e.r = N'(xi - (xi / yi) * yi);
        end
        return e;
    endfunction

    function automatic logic [31:0] pack(input logic [N-1:0] z, input logic [N-1:0] r,
                                         input logic [TAGW-1:0] tag, input logic dz, input logic ovf);
        return 32'({z, r, tag, dz, ovf});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edges);
        end
    endtask

    task automatic set_in(input logic v, input int x, input int y, input int tag);
        bus.in_valid = v;
        bus.in_x     = N'(x);
        bus.in_y     = N'(y);
        bus.in_tag   = TAGW'(tag);
    endtask

    // Compares outputs against the model, then books the handshakes of the coming edge.
    task automatic cycle();
        logic exp_valid;
        exp_t tmp;
        #1;
        exp_valid = (exp_q.size() > 0) && (edges >= exp_q[0].acc + LAT);
        check("in_ready", 32'(bus.in_ready), 32'(!reset && (exp_q.size() < DEPTH)));
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
        if (bus.out_valid && exp_valid)
            check("result", pack(bus.out_z, bus.out_r, bus.out_tag, bus.out_dz, bus.out_ovf),
                  pack(exp_q[0].z, exp_q[0].r, exp_q[0].tag, exp_q[0].dz, exp_q[0].ovf));
        if (!reset) begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) tmp = exp_q.pop_front();
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_op(bus.in_x, bus.in_y, bus.in_tag, edges + 1));
        end
        @(posedge clock);
        edges++;
        if (reset) exp_q.delete();
        @(negedge clock);
    endtask

    task automatic drain();
        set_in(1'b0, 0, 0, 0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) cycle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, acc;
        int bx[3], by[3], sx[4], sy[4];
        bx = '{10, -13, -8};
        by = '{4, 4, 3};
        sx = '{3, 5, -8, -7};
        sy = '{1, 0, -1, 2};

        set_in(1'b0, 0, 0, 0);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_div_x", 32'(bus.div_x), 32'd0);
        check("rst_div_y", 32'(bus.div_y), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        cycle();

        // single op latency
        bus.out_ready = 1'b1;
        set_in(1'b1, 7, 3, 1);
        cycle();
        set_in(1'b0, 0, 0, 0);
        n = 1;
        while (!bus.out_valid && n < 40) begin
            cycle();
            n++;
        end
        check("single_lat", 32'(n - 1), 32'(LAT));
        drain();

        // back-to-back
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, bx[i], by[i], i);
            cycle();
        end
        drain();

        // specials among normal ops
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, sx[i], sy[i], i);
            cycle();
        end
        drain();

        // backpressure
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < LAT + DEPTH + 4; i++) begin
            set_in(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(1, 7)), i);
            #1;
            if (bus.in_ready) acc++;
            cycle();
        end
        check("bp_accepts", 32'(acc), 32'(DEPTH));
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        drain();

        // simultaneous push/pop at DEPTH-1 occupancy
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_in(1'b1, i + 1, 1, i);
            cycle();
        end
        set_in(1'b0, 0, 0, 0);
        repeat (LAT + 1) cycle();
        set_in(1'b1, 9, 2, 3);
        cycle();
        set_in(1'b0, 0, 0, 0);
        repeat (LAT - 1) cycle();
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        repeat (2) cycle();
        check("pp_in_ready", 32'(bus.in_ready), 32'd1);
        drain();

        // reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, i + 2, 1, i);
            cycle();
        end
        set_in(1'b0, 0, 0, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (LAT + 3) cycle();
        set_in(1'b1, 6, 2, 2);
        cycle();
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int x, y;
            x = ($urandom_range(0, 5) == 0) ? -(1 << (N - 1)) : int'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0:       y = 0;
                1:       y = -1;
                default: y = int'($urandom_range(0, 15));
            endcase
            set_in(1'($urandom_range(0, 1)), x, y, int'($urandom_range(0, 3)));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
